// File: rtl/decode_stage.sv
// decode_stage: registered, handshaked MIPS decode stage between fetch and execute.
//
// Instructions are decoded combinationally on entry and held decoded in a head
// register (drives out_*) plus one skid register. A load-use interlock holds
// out_valid low for LOAD_USE_BUBBLES cycles after a load whose destination the
// following instruction reads.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        fetch handshake; in_insn / in_pc payload
//   flush                    drop everything held (taken branch/jump)
//   out_valid/out_ready      execute handshake
//   out_pc, out_rs, out_rt   PC and source register specifiers
//   out_wreg, out_imm        write destination, extended immediate
//   out_ctrl                 [0]BR [1]JP [2]JR [3]ALUINB [4]ALUOP [5]DMWE
//                            [6]RWE [7]RDST [8]RWD [9]LINK [10]ILLEGAL
//   out_noop                 instruction word was all zeros
//
// Optional feature: define DECODE_MUL_EN to decode SPECIAL2 MUL as RWE|RDST;
// otherwise MUL decodes as ILLEGAL.
module decode_stage #(
  parameter int unsigned ADDR_W           = 32,
  parameter int unsigned DATA_W           = 32,
  parameter int unsigned LOAD_USE_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_insn,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_wreg,
  output logic [DATA_W-1:0] out_imm,
  output logic [10:0]       out_ctrl,
  output logic              out_noop
);

  localparam logic [10:0] CBr     = 11'h001;
  localparam logic [10:0] CJp     = 11'h002;
  localparam logic [10:0] CJr     = 11'h004;
  localparam logic [10:0] CAluinb = 11'h008;
  localparam logic [10:0] CAluop  = 11'h010;
  localparam logic [10:0] CDmwe   = 11'h020;
  localparam logic [10:0] CRwe    = 11'h040;
  localparam logic [10:0] CRdst   = 11'h080;
  localparam logic [10:0] CRwd    = 11'h100;
  localparam logic [10:0] CLink   = 11'h200;
  localparam logic [10:0] CIll    = 11'h400;

  localparam logic [1:0]  Bubbles = 2'(LOAD_USE_BUBBLES);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        wreg;
    logic [DATA_W-1:0] imm;
    logic [10:0]       ctrl;
    logic              noop;
    logic              rd_rs;  // instruction reads rs
    logic              rd_rt;  // instruction reads rt
  } entry_t;

  entry_t      head_q, head_d, skid_q, skid_d, dec;
  logic        head_valid_q, head_valid_d, skid_valid_q, skid_valid_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [4:0]  lu_reg_q, lu_reg_d;
  logic        in_fire, out_fire, stall;

  logic [5:0]  opcode, funct;
  logic [15:0] imm16;
  logic [10:0] ctrl;
  logic        rd_rt, zext, lui;

  assign opcode = in_insn[31:26];
  assign funct  = in_insn[5:0];
  assign imm16  = in_insn[15:0];

  // Instruction class decode.
  always_comb begin
    ctrl  = CIll;
    rd_rt = 1'b0;
    zext  = 1'b0;
    lui   = 1'b0;
    case (opcode)
      6'b000000: begin
        rd_rt = 1'b1;
        case (funct)
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011,
          6'b000000, 6'b000010, 6'b000011,
          6'b000100, 6'b000110, 6'b000111,
          6'b010000, 6'b010010:             ctrl = CRwe | CRdst;
          6'b011010, 6'b011011:             ctrl = '0;
          6'b001000:                        ctrl = CJp | CJr;
          6'b001001:                        ctrl = CJp | CJr | CRwe | CRdst | CLink;
          default:                          ctrl = CIll;
        endcase
      end
      6'b000100, 6'b000101: begin
        ctrl  = CBr | CAluop;
        rd_rt = 1'b1;
      end
      6'b000001, 6'b000110, 6'b000111:     ctrl = CBr | CAluop;
      6'b000010:                           ctrl = CJp;
      6'b000011:                           ctrl = CJp | CRwe | CLink;
      6'b001001, 6'b001010, 6'b001011:     ctrl = CAluinb | CRwe;
      6'b001100, 6'b001101, 6'b001110: begin
        ctrl = CAluinb | CRwe;
        zext = 1'b1;
      end
      6'b001111: begin
        ctrl = CAluinb | CRwe;
        lui  = 1'b1;
      end
      6'b100011, 6'b100000, 6'b100100:     ctrl = CAluinb | CRwe | CRwd;
      6'b101011, 6'b101000: begin
        ctrl  = CAluinb | CDmwe;
        rd_rt = 1'b1;
      end
`ifdef DECODE_MUL_EN
      6'b011100: begin
        rd_rt = 1'b1;
        ctrl  = (funct == 6'b000010) ? (CRwe | CRdst) : CIll;
      end
`endif
      default:                             ctrl = CIll;
    endcase
    if (in_insn == 32'h0) ctrl = '0;
  end

  always_comb begin
    dec.pc    = in_pc;
    dec.rs    = in_insn[25:21];
    dec.rt    = in_insn[20:16];
    dec.ctrl  = ctrl;
    dec.noop  = (in_insn == 32'h0);
    dec.rd_rs = (opcode != 6'b000010) && (opcode != 6'b000011);
    dec.rd_rt = rd_rt;
    if (ctrl[7])                 dec.wreg = in_insn[15:11];
    else if (opcode == 6'b000011) dec.wreg = 5'd31;
    else                         dec.wreg = in_insn[20:16];
    if (lui)       dec.imm = DATA_W'({imm16, 16'h0000});
    else if (zext) dec.imm = DATA_W'(imm16);
    else           dec.imm = {{(DATA_W-16){imm16[15]}}, imm16};
  end

  // Interlock: hold the head while a recent load's destination is still in flight.
  assign stall = (cnt_q != 2'd0) &&
                 ((head_q.rd_rs && (head_q.rs == lu_reg_q)) ||
                  (head_q.rd_rt && (head_q.rt == lu_reg_q)));

  assign in_ready  = ~skid_valid_q;
  assign out_valid = head_valid_q & ~stall;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  always_comb begin
    head_d       = head_q;
    skid_d       = skid_q;
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    lu_reg_d     = lu_reg_q;

    if (flush) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q || out_fire) begin
      // Head frees up: skid first to keep order, else the incoming word.
      if (skid_valid_q) begin
        head_d       = skid_q;
        head_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (in_fire) begin
        head_d       = dec;
        head_valid_d = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end

    if (flush) begin
      cnt_d = 2'd0;
    end else if (out_fire && head_q.ctrl[8] && (head_q.wreg != 5'd0)) begin
      cnt_d    = Bubbles;
      lu_reg_d = head_q.wreg;
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= '0;
      skid_q       <= '0;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= 2'd0;
      lu_reg_q     <= 5'd0;
    end else begin
      head_q       <= head_d;
      skid_q       <= skid_d;
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
      lu_reg_q     <= lu_reg_d;
    end
  end

  assign out_pc   = head_q.pc;
  assign out_rs   = head_q.rs;
  assign out_rt   = head_q.rt;
  assign out_wreg = head_q.wreg;
  assign out_imm  = head_q.imm;
  assign out_ctrl = head_q.ctrl;
  assign out_noop = head_q.noop;

endmodule
